// File: rtl/servo_ramp_controller.sv
// Command stage for Servo_Driver: accepts targets over valid/ready and slews the
// commanded rotation toward the target by at most STEP_SIZE per servo frame.
module servo_ramp_controller #(
  parameter int unsigned TICK_CYCLES   = 1000000,
  parameter int unsigned STEP_SIZE     = 4,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter logic [7:0]  INIT_POS      = 8'd128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  output logic [7:0] rotation,
  output logic       set_rotation,
  output logic       at_target
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [7:0]    STEP        = 8'(STEP_SIZE);
  localparam logic [7:0]    STROBE_LAST = 8'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    STEP_ST,
    STROBE
  } state_t;

  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [7:0]        target;
  logic [7:0]        strobe_cnt;
  logic              xfer;
  logic signed [8:0] diff;
  logic [7:0]        abs_diff;
  logic [7:0]        step_pos;

  assign tick = (tick_cnt == TICK_LAST);
  assign xfer = cmd_valid && cmd_ready;

  // Frame timer runs regardless of FSM state so update spacing stays fixed.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Next position for one slew step; a 9-bit signed difference cannot wrap,
  // so stepping past 0 or 255 is impossible by construction.
  // NOTE: every always_comb output gets a value on every path to avoid latches.
  always_comb begin
    diff     = $signed({1'b0, target}) - $signed({1'b0, rotation});
    abs_diff = diff[8] ? 8'(-diff) : diff[7:0];
    step_pos = rotation;
    if (abs_diff <= STEP) begin
      step_pos = target;
    end else if (diff[8]) begin
      step_pos = rotation - STEP;
    end else begin
      step_pos = rotation + STEP;
    end
  end

  // NOTE: asynchronous reset clears every output at once, so set_rotation drops
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= INIT;
      rotation     <= INIT_POS;
      target       <= INIT_POS;
      set_rotation <= 1'b0;
      cmd_ready    <= 1'b0;
      at_target    <= 1'b0;
      strobe_cnt   <= '0;
    end else begin
      if (xfer) begin
        target <= cmd_target;
      end

      unique case (state)
        // Driver register has no reset; rotation is already stable, so the
        // strobe can rise immediately.
        INIT: begin
          state        <= STROBE;
          set_rotation <= 1'b1;
          strobe_cnt   <= '0;
        end

        IDLE: begin
          if (tick && (rotation != target)) begin
            state     <= STEP_ST;
            at_target <= 1'b0;
          end else begin
            at_target <= (rotation == (xfer ? cmd_target : target));
          end
        end

        STEP_ST: begin
          rotation   <= step_pos;
          state      <= STROBE;
          cmd_ready  <= 1'b0;
          strobe_cnt <= '0;
        end

        // After a step, the first STROBE cycle keeps set_rotation low so the
        // new rotation is settled a full cycle before the rising edge.
        STROBE: begin
          if (!set_rotation) begin
            set_rotation <= 1'b1;
          end else if (strobe_cnt == STROBE_LAST) begin
            set_rotation <= 1'b0;
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            at_target    <= (rotation == target);
          end else begin
            strobe_cnt <= strobe_cnt + 8'd1;
          end
        end

        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule
